// File: rtl/simd_shift_seq_pkg.sv
// Shared types and constants for the SIMD iterative shifter.
// Contents: lane-mode and FSM state enums, DATA_W/AMT_W, per-mode amount
// masks and lane boundary masks used by the single-step datapath.
package simd_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned AMT_W  = 4;

  typedef enum logic [1:0] {
    LANE_H = 2'b00,  // 1 x 16
    LANE_O = 2'b01,  // 2 x 8
    LANE_Q = 2'b10   // 4 x 4
  } lane_mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

  localparam logic [AMT_W-1:0] AMT_MASK_H = 4'hF;
  localparam logic [AMT_W-1:0] AMT_MASK_O = 4'h7;
  localparam logic [AMT_W-1:0] AMT_MASK_Q = 4'h3;

  // Raw mode 2'b11 is folded onto the 1x16 mode.
  function automatic lane_mode_t norm_mode(input logic [1:0] m);
    case (m)
      2'b01:   norm_mode = LANE_O;
      2'b10:   norm_mode = LANE_Q;
      default: norm_mode = LANE_H;
    endcase
  endfunction

  function automatic logic [AMT_W-1:0] amt_mask(input lane_mode_t m);
    case (m)
      LANE_O:  amt_mask = AMT_MASK_O;
      LANE_Q:  amt_mask = AMT_MASK_Q;
      default: amt_mask = AMT_MASK_H;
    endcase
  endfunction

  // One bit set at the LSB position of every lane.
  function automatic logic [DATA_W-1:0] lane_lsb_mask(input lane_mode_t m);
    case (m)
      LANE_O:  lane_lsb_mask = 16'h0101;
      LANE_Q:  lane_lsb_mask = 16'h1111;
      default: lane_lsb_mask = 16'h0001;
    endcase
  endfunction

  // One bit set at the MSB position of every lane.
  function automatic logic [DATA_W-1:0] lane_msb_mask(input lane_mode_t m);
    case (m)
      LANE_O:  lane_msb_mask = 16'h8080;
      LANE_Q:  lane_msb_mask = 16'h8888;
      default: lane_msb_mask = 16'h8000;
    endcase
  endfunction

  // Distance from lane LSB to lane MSB (lane width - 1).
  function automatic logic [3:0] lane_top_bit(input lane_mode_t m);
    case (m)
      LANE_O:  lane_top_bit = 4'd7;
      LANE_Q:  lane_top_bit = 4'd3;
      default: lane_top_bit = 4'd15;
    endcase
  endfunction

endpackage

// File: rtl/simd_shift_seq_if.sv
// Request/result bus of the SIMD iterative shifter.
// Request side: in_valid/in_ready, in_data, in_amt, in_mode, in_left,
// in_arith, in_rot. Result side: out_valid/out_ready, out_data, plus busy.
// master = requester/consumer, slave = the shifter.
interface simd_shift_seq_if import simd_pkg::*; ();
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [AMT_W-1:0]  in_amt;
  logic [1:0]        in_mode;
  logic              in_left;
  logic              in_arith;
  logic              in_rot;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              busy;

  modport master (
    output in_valid, in_data, in_amt, in_mode, in_left, in_arith, in_rot,
    output out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_mode, in_left, in_arith, in_rot,
    input  out_ready,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/simd_shift_seq_step.sv
// simd_step: combinational single-bit, lane-aware shift of a 16-bit word.
// Ports: data (operand), mode (lane mode), left (direction), arith (MSB fill
// on right shifts), rot (rotate within lane), result (data after one step).
// Optional feature macro: SIMD_SHIFT_ROTATE_EN enables rotate; otherwise rot
// is ignored and no rotate logic exists.
module simd_step import simd_pkg::*; (
  input  logic [DATA_W-1:0] data,
  input  lane_mode_t        mode,
  input  logic              left,
  input  logic              arith,
  input  logic              rot,
  output logic [DATA_W-1:0] result
);

  logic [DATA_W-1:0] lsb_m;
  logic [DATA_W-1:0] msb_m;

`ifdef SIMD_SHIFT_ROTATE_EN
  logic [3:0] top;
`else
  logic rot_unused;
  assign rot_unused = rot;
`endif

  // Whole-word shift, then clear the bit that crossed in from the
  // neighbouring lane and OR in each lane's own fill bit.
  always_comb begin
    lsb_m = lane_lsb_mask(mode);
    msb_m = lane_msb_mask(mode);
`ifdef SIMD_SHIFT_ROTATE_EN
    top   = lane_top_bit(mode);
`endif
    if (left) begin
      result = (data << 1) & ~lsb_m;
`ifdef SIMD_SHIFT_ROTATE_EN
      if (rot)
        result = result | ((data & msb_m) >> top);
`endif
    end else begin
      result = (data >> 1) & ~msb_m;
`ifdef SIMD_SHIFT_ROTATE_EN
      if (rot)
        result = result | ((data & lsb_m) << top);
      else if (arith)
        result = result | (data & msb_m);
`else
      if (arith)
        result = result | (data & msb_m);
`endif
    end
  end

endmodule

// File: rtl/simd_shift_seq.sv
// simd_shift_seq: iterative multi-bit SIMD shifter (16-bit, H/O/Q lanes).
// Ports: clk, rst (synchronous, active-high), bus (simd_shift_seq_if.slave):
// request in_* with in_valid/in_ready, result out_data with
// out_valid/out_ready, busy high while a request is in flight.
// One lane-aware step per cycle; result valid k+1 cycles after accept.
// Optional feature macro: SIMD_SHIFT_ROTATE_EN (rotate within lane).
module simd_shift_seq import simd_pkg::*; (
  input logic             clk,
  input logic             rst,
  simd_shift_seq_if.slave bus
);

  state_t            state;
  logic [DATA_W-1:0] work;
  lane_mode_t        mode_q;
  logic              left_q;
  logic              arith_q;
  logic              rot_q;
  logic [AMT_W-1:0]  k;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              busy_q;

  lane_mode_t        req_mode;
  logic [AMT_W-1:0]  req_k;
  logic [DATA_W-1:0] step_data;

  assign req_mode = norm_mode(bus.in_mode);
  assign req_k    = bus.in_amt & amt_mask(req_mode);

  simd_step u_step (
    .data   (work),
    .mode   (mode_q),
    .left   (left_q),
    .arith  (arith_q),
    .rot    (rot_q),
    .result (step_data)
  );

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.busy      = busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      work        <= '0;
      mode_q      <= LANE_H;
      left_q      <= 1'b0;
      arith_q     <= 1'b0;
      rot_q       <= 1'b0;
      k           <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.in_valid) begin
            work    <= bus.in_data;
            mode_q  <= req_mode;
            left_q  <= bus.in_left;
            arith_q <= bus.in_arith;
            rot_q   <= bus.in_rot;
            k       <= req_k;
            busy_q  <= 1'b1;
            state   <= (req_k != '0) ? ST_SHIFT : ST_DONE;
          end
        end
        ST_SHIFT: begin
          work <= step_data;
          k    <= k - 1'b1;
          if (k == 4'd1)
            state <= ST_DONE;
        end
        ST_DONE: begin
          // First DONE cycle publishes the result; the handshake is only
          // honoured once out_valid is actually visible.
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
            out_data_q  <= work;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
